note_detect: RTL and testbench

NOTE_DETECT -- requirements
Module: note_detect

---
 rtl/note_detect.sv | 144 ++++++++++++++
 tb/tb_note_detect.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/note_detect.sv
// note_detect: measures the period of a square-wave input in prescaled ticks
// and classifies it into {octave, note} over C2..B6 by octave normalisation
// (doubling) followed by a descending threshold search within one octave.
module note_detect #(
  parameter int unsigned TICK_DIV = 2500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sig_in,
  output logic [6:0] note_out,
  output logic       note_valid,
  output logic       done,
  output logic       range_err,
  output logic       busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [12:0] CNT_MAX = '1;
  localparam logic [12:0] P_MAX   = 13'd6326;
  localparam logic [12:0] P_MIN   = 13'd12;
  localparam logic [12:0] OCT_TH  = 13'd3075;

  // Lower bound of each note's period band inside the normalised octave;
  // the final zero entry makes B accept whatever is left.
  localparam logic [12:0] MID [12] = '{
    13'd5803, 13'd5478, 13'd5171, 13'd4881, 13'd4607, 13'd4348,
    13'd4103, 13'd3875, 13'd3658, 13'd3459, 13'd3265, 13'd0
  };

  typedef enum logic [1:0] {IDLE, OCT, NOTE} state_t;

  state_t         state;
  logic           s1, s2, s3;
  logic [PW-1:0]  pre;
  logic [12:0]    cnt;
  logic           armed;
  logic [12:0]    p;
  logic [2:0]     o;
  logic [3:0]     n;

  logic           rise;
  logic           tick;
  logic           timeout;
  logic           capture;
  logic [13:0]    sum;
  logic [12:0]    period;

  assign rise    = s2 & ~s3;
  assign tick    = (pre == PRE_LAST);
  assign timeout = (cnt == CNT_MAX);
  assign capture = rise & armed & ~timeout;
  assign sum     = {1'b0, cnt} + 14'(tick);
  assign period  = sum[13] ? CNT_MAX : sum[12:0];
  assign busy    = (state != IDLE);

  // Two-flop synchronizer plus one delay flop for rising-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Free-running prescaler producing the measurement tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre <= '0;
    else     pre <= tick ? '0 : pre + PW'(1);
  end

  // Saturating tick counter; any edge restarts it and (re)arms, timeout disarms
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (rise) begin
      cnt   <= '0;
      armed <= 1'b1;
    end else if (timeout) begin
      armed <= 1'b0;
    end else if (tick) begin
      cnt <= cnt + 13'd1;
    end
  end

  // Classifier FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      p          <= '0;
      o          <= '0;
      n          <= '0;
      note_out   <= '0;
      note_valid <= 1'b0;
      done       <= 1'b0;
      range_err  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (timeout) note_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            if (period > P_MAX || period < P_MIN) begin
              done       <= 1'b1;
              range_err  <= 1'b1;
              note_valid <= 1'b0;
            end else begin
              p     <= period;
              o     <= '0;
              state <= OCT;
            end
          end
        end
        OCT: begin
          if (p >= OCT_TH || o == 3'd4) begin
            n     <= '0;
            state <= NOTE;
          end else begin
            p <= {p[11:0], 1'b0};
            o <= o + 3'd1;
          end
        end
        NOTE: begin
          if (p >= MID[n] || n == 4'd11) begin
            note_out   <= {o, n};
            done       <= 1'b1;
            note_valid <= 1'b1;
            range_err  <= (p < OCT_TH);
            state      <= IDLE;
          end else begin
            n <= n + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_detect.sv
// Testbench for note_detect (TICK_DIV=1): stimulus pushes expected
// classifications and busy windows; a monitor pops and compares on done.
module tb_note_detect;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sig_in = 1'b0;
  logic [6:0] note_out;
  logic       note_valid;
  logic       done;
  logic       range_err;
  logic       busy;

  note_detect #(.TICK_DIV(1)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .note_out(note_out),
    .note_valid(note_valid), .done(done), .range_err(range_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [6:0]  note;
    logic        valid;
    logic        rerr;
    int unsigned at;
  } exp_t;

  exp_t        sbq[$];
  int unsigned win_s[$];
  int unsigned win_e[$];
  int          total = 0;
  int          bad = 0;

  bit          armed = 1'b0;
  int unsigned last_t = 0;
  logic [6:0]  last_note = '0;

  // Reference: a sig_in rise driven while cyc==t reaches the FSM at the
  // posedge ending cycle t+3. Classification by doubling then band search.
  task automatic model_edge(input int unsigned t);
    int unsigned g, p, o, n, lat;
    int unsigned mids [11] = '{5803, 5478, 5171, 4881, 4607, 4348,
                               4103, 3875, 3658, 3459, 3265};
    exp_t e;
    g = t - last_t;
    last_t = t;
    if (!armed || g >= 8192) begin
      armed = 1'b1;
      return;
    end
    if (win_e.size() > 0 && t + 3 <= win_e[win_e.size()-1] + 1) return;
    if (g > 6326 || g < 12) begin
      e.note = last_note; e.valid = 1'b0; e.rerr = 1'b1; e.at = t + 3;
      sbq.push_back(e);
      return;
    end
    p = g; o = 0; n = 0;
    while (p < 3075 && o < 4) begin p = p * 2; o++; end
    while (n < 11 && p < mids[n]) n++;
    lat = (o + 1) + (n + 1);
    e.note = {o[2:0], n[3:0]}; e.valid = 1'b1; e.rerr = (p < 3075);
    e.at = t + 3 + lat;
    sbq.push_back(e);
    win_s.push_back(t + 3);
    win_e.push_back(t + 2 + lat);
    last_note = e.note;
  endtask

  task automatic model_reset();
    sbq.delete(); win_s.delete(); win_e.delete();
    armed = 1'b0;
    last_note = '0;
  endtask

  // Drive a one-cycle-high pulse rising `gap` cycles after the previous one
  task automatic edge_after(input int unsigned gap);
    while (cyc < last_t + gap) @(negedge clk);
    sig_in = 1'b1;
    model_edge(cyc);
    @(negedge clk);
    sig_in = 1'b0;
  endtask

  task automatic check_zero(input string name);
    total++;
    if ({note_out, note_valid, done, range_err, busy} !== 11'd0) begin
      bad++;
      $display("FAIL %s outputs got=%h want=0", name,
               {note_out, note_valid, done, range_err, busy});
    end
  endtask

  // Monitor: busy against expected windows every cycle; pop on done
  initial begin
    exp_t e;
    bit   bexp;
    forever begin
      @(posedge clk);
      #1;
      while (win_e.size() > 0 && win_e[0] < cyc) begin
        void'(win_s.pop_front());
        void'(win_e.pop_front());
      end
      bexp = (win_s.size() > 0) && cyc >= win_s[0] && cyc <= win_e[0];
      total++;
      if (busy !== bexp) begin
        bad++;
        $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, bexp);
      end
      if (done === 1'b1) begin
        total++;
        if (sbq.size() == 0) begin
          bad++;
          $display("FAIL unexpected_done cyc=%0d note=%h", cyc, note_out);
        end else begin
          e = sbq.pop_front();
          if (note_out !== e.note || note_valid !== e.valid ||
              range_err !== e.rerr || cyc != e.at) begin
            bad++;
            $display("FAIL done got note=%h valid=%b rerr=%b cyc=%0d want note=%h valid=%b rerr=%b cyc=%0d",
                     note_out, note_valid, range_err, cyc,
                     e.note, e.valid, e.rerr, e.at);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned sel, gap;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    last_t = cyc;

    // Directed periods, including range boundaries
    edge_after(10);
    edge_after(5971);
    edge_after(5971);
    edge_after(1493);
    edge_after(837);
    edge_after(100);
    edge_after(7000);
    edge_after(11);
    edge_after(6327);
    edge_after(6326);
    edge_after(12);

    // Random periods, with short gaps that land inside busy windows
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      gap = $urandom_range(2, 18);
      else if (sel == 1) gap = $urandom_range(9, 14);
      else               gap = $urandom_range(12, 1600);
      edge_after(gap);
    end

    // Timeout: valid drops, note_out holds, next edge only arms
    while (cyc < last_t + 8300) @(negedge clk);
    total++;
    if (note_valid !== 1'b0 || note_out !== last_note) begin
      bad++;
      $display("FAIL timeout got valid=%b note=%h want valid=0 note=%h",
               note_valid, note_out, last_note);
    end
    edge_after(8400);
    edge_after(5971);

    // Reset in the middle of a classification
    edge_after(50);
    edge_after(100);
    while (cyc < last_t + 9) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL busy_before_rst got=%b want=1", busy);
    end
    rst = 1'b1;
    model_reset();
    #1;
    check_zero("mid_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_t = cyc;
    edge_after(40);
    edge_after(5971);

    repeat (40) @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL pending got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
